// File: rtl/fifo_rd_packer_if.sv
// Bundle of the FIFO read port, the packed output stream and the flush
// handshake of fifo_rd_packer. The packer uses the master modport; whatever
// sits around it (FIFO plus downstream consumer) uses the slave modport.
interface fifo_rd_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    logic                        fifo_empty;
    logic                        fifo_rd_en;
    logic [DATA_WIDTH-1:0]       fifo_rd_data;
    logic                        flush;
    logic                        m_valid;
    logic                        m_ready;
    logic [RATIO*DATA_WIDTH-1:0] m_data;
    logic [RATIO-1:0]            m_keep;
    logic                        m_last;
    logic                        flush_done;

    modport master (
        input  fifo_empty, fifo_rd_data, flush, m_ready,
        output fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done
    );

    modport slave (
        output fifo_empty, fifo_rd_data, flush, m_ready,
        input  fifo_rd_en, m_valid, m_data, m_keep, m_last, flush_done
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Read-side packer: pops DATA_WIDTH words from a FIFO with 1-cycle read
// latency, packs RATIO of them into one beat on a valid/ready stream, and
// on a flush pulse pushes out whatever partial beat is accumulated.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic               rd_clk,
    input  logic               rst,
    fifo_rd_packer_if.master   bus
);
    localparam int CW = $clog2(RATIO + 1);
    localparam int LW = $clog2(RATIO);
    localparam logic [CW:0]   RATIO_X = (CW + 1)'(RATIO);
    localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_FL_WAIT = 2'd1;
    localparam logic [1:0] ST_FL_EMIT = 2'd2;

    logic [1:0]                  state_reg;
    logic [1:0]                  state_next;
    logic [CW-1:0]               cnt_reg;
    logic                        pop_d_reg;
    logic [DATA_WIDTH-1:0]       acc_reg [RATIO];
    logic                        m_valid_reg;
    logic [RATIO*DATA_WIDTH-1:0] m_data_reg;
    logic [RATIO-1:0]            m_keep_reg;
    logic                        m_last_reg;
    logic                        flush_done_reg;
    logic                        flush_done_next;

    logic                        out_free;
    logic                        xfer;
    logic                        emit;
    logic                        fill_ok;
    logic                        pop;
    logic [RATIO-1:0]            lane_mask;
    logic [RATIO*DATA_WIDTH-1:0] packed_beat;

    // The output register can take a new beat when empty or being drained.
    assign out_free = !m_valid_reg || bus.m_ready;
    // Full beat handover only happens in normal running; a flush emits its
    // own beat from FL_EMIT (which also covers a full accumulator).
    assign xfer     = (state_reg == ST_RUN) && (cnt_reg == RATIO_C) && out_free;
    assign emit     = (state_reg == ST_FL_EMIT) && out_free;
    // Counting the in-flight word keeps the lane index below RATIO.
    assign fill_ok  = ({1'b0, cnt_reg} + {{CW{1'b0}}, pop_d_reg}) < RATIO_X;
    // Gated by rst as well so no word is popped and lost while in reset.
    assign pop      = !rst && !bus.fifo_empty && (state_reg == ST_RUN) &&
                      !bus.flush && (fill_ok || xfer);

    assign bus.fifo_rd_en = pop;
    assign bus.m_valid    = m_valid_reg;
    assign bus.m_data     = m_data_reg;
    assign bus.m_keep     = m_keep_reg;
    assign bus.m_last     = m_last_reg;
    assign bus.flush_done = flush_done_reg;

    // Lanes below cnt hold real data; the rest are zeroed and unkept. With
    // cnt == RATIO this yields the full beat with an all-ones keep.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_mask[gi] = cnt_reg > CW'(gi);
            assign packed_beat[gi*DATA_WIDTH +: DATA_WIDTH] =
                lane_mask[gi] ? acc_reg[gi] : '0;
        end
    endgenerate

    // Flush sequencing: wait for the in-flight word, then emit or finish.
    always_comb begin
        state_next      = state_reg;
        flush_done_next = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (bus.flush) state_next = ST_FL_WAIT;
            end
            ST_FL_WAIT: begin
                if (!pop_d_reg) begin
                    if (cnt_reg == '0) begin
                        state_next      = ST_RUN;
                        flush_done_next = 1'b1;
                    end else begin
                        state_next = ST_FL_EMIT;
                    end
                end
            end
            ST_FL_EMIT: begin
                if (out_free) begin
                    state_next      = ST_RUN;
                    flush_done_next = 1'b1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Word capture into the accumulator lane selected by the fill count.
    always_ff @(posedge rd_clk) begin
        if (pop_d_reg) acc_reg[cnt_reg[LW-1:0]] <= bus.fifo_rd_data;
    end

    // Control state, fill count and the output register.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            state_reg      <= ST_RUN;
            cnt_reg        <= '0;
            pop_d_reg      <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            m_last_reg     <= 1'b0;
            flush_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pop_d_reg      <= pop;
            flush_done_reg <= flush_done_next;
            if (xfer || emit) begin
                cnt_reg <= '0;
            end else if (pop_d_reg) begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (xfer || emit) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= packed_beat;
                m_keep_reg  <= lane_mask;
                m_last_reg  <= emit;
            end else if (bus.m_ready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer (DATA_WIDTH=8, RATIO=4) with a queue
// standing in for the FIFO and a per-cycle monitor of the output stream.
module tb_fifo_rd_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_packer_if #(.DATA_WIDTH(8), .RATIO(4)) bus ();

    fifo_rd_packer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .rd_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int rden_cnt = 0;
    int valid_cnt = 0;

    logic [7:0]  fq [$];
    logic [31:0] beat_data [$];
    logic [3:0]  beat_keep [$];
    logic        beat_last [$];
    int          beat_cyc  [$];
    int          fd_cyc    [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // One clock: sample at negedge, then update the FIFO model after posedge.
    task automatic tick();
        logic popped;
        @(negedge clk);
        popped = bus.fifo_rd_en;
        if (bus.fifo_rd_en) rden_cnt++;
        if (bus.m_valid) valid_cnt++;
        if (bus.m_valid && bus.m_ready) begin
            beat_data.push_back(bus.m_data);
            beat_keep.push_back(bus.m_keep);
            beat_last.push_back(bus.m_last);
            beat_cyc.push_back(cyc);
        end
        if (bus.flush_done) fd_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (popped && fq.size() > 0) begin
            bus.fifo_rd_data = fq.pop_front();
            pops++;
        end
        bus.fifo_empty = (fq.size() == 0);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_words(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) fq.push_back(first + 8'(i));
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic clear_mon();
        beat_data.delete();
        beat_keep.delete();
        beat_last.delete();
        beat_cyc.delete();
        fd_cyc.delete();
        valid_cnt = 0;
        rden_cnt  = 0;
    endtask

    function automatic logic [31:0] bd(input int i);
        return (beat_data.size() > i) ? beat_data[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int bc(input int i);
        return (beat_cyc.size() > i) ? beat_cyc[i] : -1;
    endfunction

    initial begin
        int c0;
        logic [31:0] held;
        bus.fifo_empty   = 1'b1;
        bus.fifo_rd_data = 8'h00;
        bus.flush        = 1'b0;
        bus.m_ready      = 1'b1;

        // 1: reset values, then idle with an empty FIFO
        ticks(2);
        check_eq("rst_m_valid", 64'(bus.m_valid), 64'h0);
        check_eq("rst_m_data", 64'(bus.m_data), 64'h0);
        check_eq("rst_m_keep", 64'(bus.m_keep), 64'h0);
        check_eq("rst_m_last", 64'(bus.m_last), 64'h0);
        check_eq("rst_flush_done", 64'(bus.flush_done), 64'h0);
        check_eq("rst_rd_en", 64'(bus.fifo_rd_en), 64'h0);
        rst = 1'b0;
        clear_mon();
        ticks(10);
        check_eq("empty_no_pop", 64'(rden_cnt), 64'h0);

        // 2: single beat
        clear_mon();
        c0 = cyc;
        fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
        bus.fifo_empty = 1'b0;
        ticks(12);
        check_eq("t2_beats", 64'(beat_data.size()), 64'd1);
        check_eq("t2_data", 64'(bd(0)), 64'h4433_2211);
        check_eq("t2_keep", 64'(beat_keep.size() > 0 ? beat_keep[0] : 4'h0), 64'hF);
        check_eq("t2_last", 64'(beat_last.size() > 0 ? beat_last[0] : 1'b1), 64'h0);
        check_eq("t2_valid_cycles", 64'(valid_cnt), 64'd1);
        check_eq("t2_latency", 64'(bc(0) - c0), 64'd6);

        // 3: streaming, one bubble per beat
        clear_mon();
        c0 = cyc;
        push_words(8'h01, 12);
        ticks(17);
        check_eq("t3_beats", 64'(beat_data.size()), 64'd3);
        check_eq("t3_data0", 64'(bd(0)), 64'h0403_0201);
        check_eq("t3_data1", 64'(bd(1)), 64'h0807_0605);
        check_eq("t3_data2", 64'(bd(2)), 64'h0C0B_0A09);
        check_eq("t3_cyc0", 64'(bc(0) - c0), 64'd6);
        check_eq("t3_cyc1", 64'(bc(1) - c0), 64'd11);
        check_eq("t3_cyc2", 64'(bc(2) - c0), 64'd16);

        // 4: backpressure holds output and stops popping at 8 words
        clear_mon();
        bus.m_ready = 1'b0;
        pops = 0;
        push_words(8'h21, 12);
        ticks(20);
        check_eq("t4_pops_held", 64'(pops), 64'd8);
        check_eq("t4_valid", 64'(bus.m_valid), 64'h1);
        held = bus.m_data;
        check_eq("t4_data_held", 64'(held), 64'h2423_2221);
        ticks(5);
        check_eq("t4_data_stable", 64'(bus.m_data), 64'(held));
        check_eq("t4_keep_stable", 64'(bus.m_keep), 64'hF);
        check_eq("t4_pops_still", 64'(pops), 64'd8);
        bus.m_ready = 1'b1;
        clear_mon();
        ticks(20);
        check_eq("t4_beats", 64'(beat_data.size()), 64'd3);
        check_eq("t4_data0", 64'(bd(0)), 64'h2423_2221);
        check_eq("t4_data1", 64'(bd(1)), 64'h2827_2625);
        check_eq("t4_data2", 64'(bd(2)), 64'h2C2B_2A29);
        check_eq("t4_pops_total", 64'(pops), 64'd12);
        check_eq("t4_no_bubble", 64'(bc(1) - bc(0)), 64'd1);

        // 5a: flush with a word in flight
        clear_mon();
        fq.push_back(8'hA1); fq.push_back(8'hA2);
        bus.fifo_empty = 1'b0;
        ticks(2);
        bus.flush = 1'b1;
        c0 = cyc;
        tick();
        bus.flush = 1'b0;
        ticks(8);
        check_eq("t5_beats", 64'(beat_data.size()), 64'd1);
        check_eq("t5_data", 64'(bd(0)), 64'h0000_A2A1);
        check_eq("t5_keep", 64'(beat_keep.size() > 0 ? beat_keep[0] : 4'h0), 64'h3);
        check_eq("t5_last", 64'(beat_last.size() > 0 ? beat_last[0] : 1'b0), 64'h1);
        check_eq("t5_beat_cyc", 64'(bc(0) - c0), 64'd3);
        check_eq("t5_fd_count", 64'(fd_cyc.size()), 64'd1);
        check_eq("t5_fd_cyc", 64'(fd_cyc.size() > 0 ? fd_cyc[0] - c0 : -1), 64'd3);

        // 5b: flush with nothing accumulated
        clear_mon();
        bus.flush = 1'b1;
        c0 = cyc;
        tick();
        bus.flush = 1'b0;
        ticks(6);
        check_eq("t5b_beats", 64'(beat_data.size()), 64'd0);
        check_eq("t5b_fd_count", 64'(fd_cyc.size()), 64'd1);
        check_eq("t5b_fd_cyc", 64'(fd_cyc.size() > 0 ? fd_cyc[0] - c0 : -1), 64'd2);

        // 6: reset mid-accumulation discards old words
        clear_mon();
        push_words(8'h51, 3);
        ticks(3);
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        check_eq("t6_valid_after_rst", 64'(bus.m_valid), 64'h0);
        check_eq("t6_keep_after_rst", 64'(bus.m_keep), 64'h0);
        push_words(8'h61, 4);
        ticks(12);
        check_eq("t6_beats", 64'(beat_data.size()), 64'd1);
        check_eq("t6_data", 64'(bd(0)), 64'h6463_6261);
        check_eq("t6_keep", 64'(beat_keep.size() > 0 ? beat_keep[0] : 4'h0), 64'hF);
        check_eq("t6_last", 64'(beat_last.size() > 0 ? beat_last[0] : 1'b1), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
